// File: rtl/alu_seq_responder.sv
// alu_seq_responder: valid/ready integer ALU with single-cycle ops and an iterative shift-add multiplier
module alu_seq_responder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int M = WIDTH - 1;
  logic [1:0] state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d, alu_res;
  logic carry_q, carry_d, zero_q, zero_d, overflow_q, overflow_d;
  logic alu_c, alu_v;
  logic [WIDTH:0] sum, diff;
  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    diff = {1'b0, A} - {1'b0, B};
    alu_res = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[M] == B[M]) && (sum[M] != A[M]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (A[M] != B[M]) && (diff[M] != A[M]);
      end
      OP_SHL: begin
        alu_res = {A[WIDTH-2:0], 1'b0};
        alu_c = A[M];
      end
      3'b111: begin
        alu_res = {1'b0, A[WIDTH-1:1]};
        alu_c = A[0];
      end
      default: alu_res = '0;
    endcase
  end
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    result_d = result_q;
    result_hi_d = result_hi_q;
    carry_d = carry_q;
    zero_d = zero_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (op == OP_MUL) begin
          acc_d = '0;
          mcand_d = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          cnt_d = '0;
          state_d = MULT;
        end else begin
          result_d = alu_res;
          result_hi_d = '0;
          carry_d = alu_c;
          zero_d = alu_res == '0;
          overflow_d = alu_v;
          state_d = DONE;
        end
      end
      MULT: begin
        acc_d = acc_step;
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d = acc_step[WIDTH-1:0];
          result_hi_d = acc_step[2*WIDTH-1:WIDTH];
          carry_d = 1'b0;
          zero_d = acc_step[WIDTH-1:0] == '0;
          overflow_d = acc_step[2*WIDTH-1:WIDTH] != '0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      result_hi_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      overflow_q <= overflow_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign result_hi = result_hi_q;
  assign carry = carry_q;
  assign zero = zero_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_alu_seq_responder.sv
// tb_alu_seq_responder: directed vector table plus backpressure and mid-multiply reset sequences
module tb_alu_seq_responder;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, carry, zero, overflow;
  logic [2:0] op;
  logic [3:0] a, b, result, result_hi;
  int pass_cnt = 0;
  int total = 0;
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a, b, r, rh;
    logic c, z, v;
  } vec_t;
  vec_t vecs[13];
  alu_seq_responder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .carry(carry), .zero(zero), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic run_op(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d in_ready_idle", idx), 32'(in_ready), 1);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = 4'hx; b = 4'hx;
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk($sformatf("v%0d in_ready_busy", idx), 32'(in_ready), 0);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), (v.op == 3'b101) ? 5 : 1);
    chk($sformatf("v%0d in_ready_done", idx), 32'(in_ready), 0);
    chk($sformatf("v%0d result", idx), 32'(result), 32'(v.r));
    chk($sformatf("v%0d result_hi", idx), 32'(result_hi), 32'(v.rh));
    chk($sformatf("v%0d flags_czv", idx), 32'({carry, zero, overflow}), 32'({v.c, v.z, v.v}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d out_valid_drop", idx), 32'(out_valid), 0);
    chk($sformatf("v%0d in_ready_back", idx), 32'(in_ready), 1);
  endtask
  initial begin
    int seen;
    vecs[0]  = '{3'b000, 4'b1010, 4'b1011, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b011, 4'b0111, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'b011, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'b100, 4'b0011, 4'b0101, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 4'b1000, 4'b0001, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'b101, 4'b1111, 4'b1111, 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'b101, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'b001, 4'b1010, 4'b0101, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b010, 4'b1100, 4'b1010, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b110, 4'b1001, 4'b1111, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b111, 4'b0110, 4'b1111, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b101, 4'b0011, 4'b0101, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b100, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a = 4'h0; b = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset outputs", 32'({result_hi, result, carry, zero, overflow}), 0);
    foreach (vecs[i]) run_op(vecs[i], i);
    // backpressure: response held while a competing request is presented
    @(negedge clk);
    op = 3'b011; a = 4'b0010; b = 4'b0011; in_valid = 1'b1;
    @(negedge clk);
    op = 3'b000; a = 4'b0000; b = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d out_valid", k), 32'(out_valid), 1);
      chk($sformatf("stall%0d result", k), 32'(result), 32'(4'b0101));
      chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release out_valid", 32'(out_valid), 0);
    chk("release in_ready", 32'(in_ready), 1);
    chk("release result held", 32'(result), 32'(4'b0101));
    in_valid = 1'b0; out_ready = 1'b0;
    // reset two cycles into a multiply
    @(negedge clk);
    op = 3'b101; a = 4'b1111; b = 4'b1111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort out_valid", 32'(out_valid), 0);
    chk("abort in_ready", 32'(in_ready), 1);
    chk("abort outputs", 32'({result_hi, result, carry, zero, overflow}), 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no response", 32'(seen), 0);
    run_op('{3'b111, 4'b1001, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0}, 99);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/alu_seq_responder.md
Name: alu_seq_responder

Overview:
- Clocked integer-ALU execution unit. Responds to an operand/opcode request from an initiator, such as the ALU stimulus bench or the future ALU sequencer.
- Logic ops (AND/OR/XOR), add/sub and shifts complete in one cycle. MUL is an iterative shift-add that takes WIDTH cycles.
- Results and flags are returned over a valid/ready response channel and held until accepted.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 SHL1, 111 SHR1.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; ignored for SHL1/SHR1.
- out_valid  output  1  response valid.
- out_ready  input  1  initiator accepts the response.
- result  output  WIDTH  result, or low word of the product for MUL.
- result_hi  output  WIDTH  high word of the product for MUL; 0 for all other ops.
- carry  output  1  see flag rules below.
- zero  output  1  result == 0 (low word only).
- overflow  output  1  see flag rules below.

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; in_ready=1; out_valid=0; result, result_hi, carry, zero, overflow all 0; MUL counter and accumulator cleared.
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept occurs on a cycle with in_valid=1; A, B and op are latched at that edge.
  - Non-MUL op: compute and register the outputs at that edge, then go to DONE. out_valid rises in cycle N+1.
  - MUL: load acc=0, mcand=A zero-extended to 2*WIDTH, mplier=B, cnt=0, then go to MULT.
- State MULT (one step per cycle):
  - If mplier[0]=1, acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - After WIDTH steps go to DONE with {result_hi, result} = acc.
  - out_valid first asserts in cycle N+1+WIDTH (cycle N+5 for WIDTH=4).
- State DONE:
  - out_valid=1; all outputs held stable.
  - If out_ready=1, go to IDLE on that edge. in_ready returns the following cycle; there is no same-cycle re-accept.
  - out_ready=0 stalls indefinitely.
- in_ready=0 in both MULT and DONE. in_valid is ignored in those states, and the initiator must hold its request.
- Arithmetic: all operands are unsigned WIDTH bits; result is truncated to WIDTH bits.
- Flag rules:
  - ADD: carry = carry-out of A+B. overflow = signed overflow, i.e. A and B have the same sign and result has a different sign.
  - SUB: result = A-B modulo 2^WIDTH. carry = borrow (1 iff A<B unsigned). overflow = signed overflow, i.e. A and B have different signs and result sign differs from A.
  - MUL: carry=0. overflow = (result_hi != 0).
  - SHL1: result = A<<1; carry = A[WIDTH-1]; overflow=0.
  - SHR1: result = A>>1, logical; carry = A[0]; overflow=0.
  - AND/OR/XOR: carry=0, overflow=0.
- Outputs register only at result time. They keep their last values after out_valid falls and are meaningful only while out_valid=1.
- Reset mid-operation: rst in MULT or DONE aborts the operation. Next cycle is IDLE with reset values and no response is emitted.
- rst has priority over in_valid and out_ready in the same cycle.

Test Plan:
- AND: A=1010, B=1011, op=000, accepted cycle N -> out_valid in N+1; result=1010, zero=0, carry=0, overflow=0.
- ADD: A=0111, B=0001 -> result=1000, carry=0, overflow=1. Then A=1111, B=0001 -> result=0000, carry=1, zero=1, overflow=0.
- SUB: A=0011, B=0101 -> result=1110, carry=1, overflow=0. Then A=1000, B=0001 -> result=0111, overflow=1.
- MUL: A=1111, B=1111, accepted cycle N -> in_ready=0 for cycles N+1..N+5; out_valid first in N+5; result_hi=1110, result=0001, overflow=1. Also 0000*1011 -> result=0000, zero=1.
- Backpressure: ADD 0010+0011 with out_ready=0 for 5 cycles -> out_valid=1 and result=0101 held throughout; a second in_valid during the stall is not accepted. Raise out_ready -> in_ready=1 the following cycle.
- Reset mid-MUL: rst pulsed 2 cycles after a MUL accept -> next cycle out_valid=0, in_ready=1, all outputs 0, no response ever issued. A subsequent SHR1 with A=1001 -> result=0100, carry=1.
